router_fifo: RTL
================

Name: router_fifo

Overview:
- 16-entry output buffer, one instance per destination port of the 1x3 router.
- Sits directly downstream of the router register stage and captures its byte stream (header, payload, parity) into a small circular store.
- Each stored byte is tagged with a header flag so the read side can track packet boundaries.
- The read side is drained by the destination's read_enb. A packet byte counter detects end-of-packet and flags it.

Parameters:
- DEPTH, 16, number of entries (power of two).
- WIDTH, 8, data byte width.
- PTR_W, 4, log2(DEPTH).

Ports:
- clock  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- soft_reset  input  1  synchronous flush from the synchronizer timeout (active-high).
- write_enb  input  1  write request from the synchronizer for this port.
- read_enb  input  1  read request from the destination.
- lfd_state  input  1  FSM load-first-data state.
- data_in  input  WIDTH  byte from the register stage dout.
- full  output  1  no free entry.
- empty  output  1  no stored entry.
- data_out  output  WIDTH  registered read data.
- pkt_done  output  1  one-cycle pulse when the last byte (parity) of a packet is read.

Behaviour:
- Async reset (resetn=0):
  - wr_ptr=rd_ptr=0, all memory tags=0, pkt_cnt=0, lfd_q=0.
  - data_out=0, pkt_done=0, full=0, empty=1.
- Header tag alignment:
  - lfd_q <= lfd_state every clock.
  - The register stage presents the header on dout one cycle after lfd_state, so the write tag is lfd_q.
- Storage:
  - Memory is DEPTH words of WIDTH+1 bits: {tag, byte}.
  - Pointers are PTR_W+1 bits, with the MSB as the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (addresses equal) and (wrap bits differ).
  - full and empty are combinational from the pointers.
- Write:
  - Accepted when write_enb=1 and full=0, with full evaluated before the edge.
  - Stores {lfd_q, data_in} at wr_ptr[PTR_W-1:0], then wr_ptr increments.
  - A write while full is dropped silently; pointers and memory are unchanged.
- Read:
  - Accepted when read_enb=1 and empty=0.
  - data_out <= stored byte at the next edge (latency 1), then rd_ptr increments.
  - With no accepted read, data_out holds its value.
- Packet counter (7 bits):
  - Read of a word with tag=1: pkt_cnt <= byte[7:2] + 1, i.e. payload length plus parity.
  - Read of a word with tag=0 and pkt_cnt != 0: pkt_cnt decrements.
  - pkt_done pulses for 1 cycle, aligned with data_out, on the read that moves pkt_cnt from 1 to 0.
  - A header of length 0 gives pkt_cnt=1, so the next read (parity) pulses pkt_done.
- Simultaneous read and write:
  - Both are permitted in the same cycle when not full and not empty; occupancy is unchanged.
  - When full, a read and write in the same cycle: only the read occurs and the write is dropped.
  - When empty, a read and write in the same cycle: only the write occurs and there is no read-through.
- soft_reset (synchronous, priority over read and write):
  - Pointers go to 0, pkt_cnt=0, data_out=0, pkt_done=0, all tags cleared.
  - Memory contents are don't-care.
- Reset mid-packet: asynchronous reset clears all state immediately. Any partially stored packet is discarded, and the header lookup restarts on the next tagged word.
- Wrap-around: pointer address bits wrap modulo DEPTH. The wrap bit toggles and the full/empty rules hold across wraps.

Decomposition:
- Shared package router_pkg holds:
  - WIDTH=8, DEPTH=16.
  - Header field positions: LEN_MSB=7, LEN_LSB=2, ADDR field [1:0].
  - PKT_CNT_W=7.
- One natural sub-module: router_fifo_ptr, a wrap-bit pointer with increment enable and sync clear. It is instantiated twice (write and read).
- The memory array and the counter stay in router_fifo.

Test Plan:
- Reset and idle:
  - Stimulus: resetn low, then high.
  - Required: empty=1, full=0, data_out=8'h00, pkt_done=0.
- Single packet:
  - Stimulus: lfd_state for 1 cycle, then write header 8'h0D (len 3, addr 01), payload 8'hA1, 8'hA2, 8'hA3, parity 8'h5F. Then read_enb continuously.
  - Required: data_out sequence 0D, A1, A2, A3, 5F on consecutive cycles after each read; pkt_done high only with 5F; empty=1 afterwards.
- Fill and overflow:
  - Stimulus: 17 writes of 8'h00..8'h10 with no reads.
  - Required: full=1 after the 16th write; 8'h10 is dropped; 16 reads return 00..0F.
- Wrap with simultaneous read/write:
  - Stimulus: pre-fill 10 bytes, then 20 cycles of concurrent write and read.
  - Required: occupancy stays 10, data_out is in order, pointers wrap with no spurious full or empty.
- Soft reset mid-packet:
  - Stimulus: store a header of length 5 plus 2 payload bytes, read the header, then pulse soft_reset.
  - Required: next cycle empty=1, data_out=0, pkt_cnt=0; a following fresh packet reads correctly with pkt_done on its parity byte.
- Zero-length packet:
  - Stimulus: header 8'h02, then parity 8'h02.
  - Required: pkt_done pulses on the second read.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants and header layout for the router output buffers.
package router_pkg;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned LEN_MSB   = 7;
  localparam int unsigned LEN_LSB   = 2;
  localparam int unsigned LEN_W     = LEN_MSB - LEN_LSB + 1;
  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned PKT_CNT_W = 7;

  // Header byte: payload length in [7:2], destination in [1:0].
  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] dest;
  } hdr_t;

  // Bytes still to read after a header: payload plus the parity byte.
  function automatic logic [PKT_CNT_W-1:0] hdr_count(input hdr_t hdr);
    return PKT_CNT_W'(hdr.len) + PKT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo_ptr.sv
// Circular-buffer pointer with a wrap bit above the address bits.
module router_fifo_ptr #(
  parameter int unsigned PTR_W = 4
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           clr,
  input  logic           inc,
  output logic [PTR_W:0] ptr
);
  import router_pkg::*;

  localparam int unsigned PW = PTR_W + 1;

  logic [PTR_W:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/router_fifo.sv
// Per-destination output buffer of the 1x3 router; tags header bytes and
// flags the read of each packet's parity byte.
module router_fifo #(
  parameter int unsigned DEPTH = router_pkg::DEPTH,
  parameter int unsigned WIDTH = router_pkg::WIDTH,
  parameter int unsigned PTR_W = router_pkg::PTR_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data_out,
  output logic             pkt_done
);
  import router_pkg::*;

  logic [PTR_W:0]       wr_ptr, rd_ptr;
  logic [PTR_W-1:0]     wr_addr, rd_addr;
  logic                 wr_ok, rd_ok;
  logic [WIDTH:0]       mem_q [DEPTH];
  logic [WIDTH:0]       mem_d [DEPTH];
  logic [WIDTH:0]       rd_word;
  logic                 lfd_q, lfd_d;
  logic [WIDTH-1:0]     data_out_q, data_out_d;
  logic                 pkt_done_q, pkt_done_d;
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  assign wr_addr = wr_ptr[PTR_W-1:0];
  assign rd_addr = rd_ptr[PTR_W-1:0];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_addr == rd_addr) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);

  // full/empty are sampled before the edge, so a full buffer still serves
  // a read and an empty buffer never reads through a same-cycle write.
  assign wr_ok = write_enb && !full;
  assign rd_ok = read_enb && !empty;

  router_fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clock  (clock),
    .resetn (resetn),
    .clr    (soft_reset),
    .inc    (wr_ok),
    .ptr    (wr_ptr)
  );

  router_fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clock  (clock),
    .resetn (resetn),
    .clr    (soft_reset),
    .inc    (rd_ok),
    .ptr    (rd_ptr)
  );

  // Header byte arrives one cycle after lfd_state, so the tag is delayed.
  assign lfd_d = lfd_state;

  always_comb begin
    mem_d = mem_q;
    if (soft_reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_d[i][WIDTH] = 1'b0;
      end
    end else if (wr_ok) begin
      mem_d[wr_addr] = {lfd_q, data_in};
    end
  end

  assign rd_word = mem_q[rd_addr];

  // Read data, packet byte counter and end-of-packet pulse.
  always_comb begin
    data_out_d = data_out_q;
    pkt_cnt_d  = pkt_cnt_q;
    pkt_done_d = 1'b0;
    if (soft_reset) begin
      data_out_d = '0;
      pkt_cnt_d  = '0;
    end else if (rd_ok) begin
      data_out_d = rd_word[WIDTH-1:0];
      if (rd_word[WIDTH]) begin
        pkt_cnt_d = hdr_count(hdr_t'(rd_word[WIDTH-1:0]));
      end else if (pkt_cnt_q != '0) begin
        pkt_cnt_d  = pkt_cnt_q - PKT_CNT_W'(1);
        pkt_done_d = (pkt_cnt_q == PKT_CNT_W'(1));
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      lfd_q      <= 1'b0;
      data_out_q <= '0;
      pkt_cnt_q  <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      lfd_q      <= lfd_d;
      data_out_q <= data_out_d;
      pkt_cnt_q  <= pkt_cnt_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  assign data_out = data_out_q;
  assign pkt_done = pkt_done_q;

endmodule
